// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator ALU: single-cycle add/sub/invalid, shift-add unsigned multiply
// with a start/busy/done handshake. Result and flags hold until the next completion.
module calc_alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               ovf,
  output logic               err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, result_q, result_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
  logic [WIDTH:0]     sum, diff;
  logic               last_step;

  // Extra top bit of sum/diff is carry-out for add and borrow for sub.
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && op == 2'b10) state_d = StMul;
      StMul:   if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            2'b00: begin
              result_d = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              carry_d  = sum[WIDTH];
              ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
              err_d    = 1'b0;
              done_d   = 1'b1;
            end
            2'b01: begin
              result_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              carry_d  = diff[WIDTH];
              ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
              err_d    = 1'b0;
              done_d   = 1'b1;
            end
            2'b10: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              cnt_d    = '0;
            end
            default: begin
              result_d = '0;
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              err_d    = 1'b1;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      StMul: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed latency: no early exit when the multiplier runs out of ones.
        if (last_step) begin
          result_d = acc_sum;
          carry_d  = 1'b0;
          ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
          err_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy   = (state_q == StMul);
    done   = done_q;
    result = result_q;
    carry  = carry_q;
    ovf    = ovf_q;
    err    = err_q;
  end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Parametrised multi-cycle arithmetic unit for the calculator datapath. Supersedes the fixed 4-bit combinational adder.
Adds subtraction, unsigned shift-add multiplication, status flags and a start/busy/done handshake.
Sits between the operand entry registers and the display formatter. One operation is in flight at a time.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16); result is 2*WIDTH bits.

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 add, 01 sub, 10 mul (unsigned), 11 invalid
a  in  WIDTH  operand A; captured on accepted start
b  in  WIDTH  operand B; captured on accepted start
busy  out  1  high while a multiply iterates
done  out  1  one-cycle pulse when result and flags update
result  out  2*WIDTH  result of the last completed operation
carry  out  1  add: carry-out; sub: borrow (a<b unsigned); mul/invalid: 0
ovf  out  1  add/sub: two's-complement overflow; mul: upper WIDTH result bits nonzero; invalid: 0
err  out  1  high when the last completed op was 11

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values: state=IDLE; busy, done, result, carry, ovf and err all 0. Internal operand, accumulator and counter registers are also cleared.
- States: IDLE, MUL.
- Accept: start=1 in IDLE at rising edge T. a, b and op are captured at edge T and may change afterwards. start is ignored in MUL; there is no queueing.
- add/sub/invalid complete at edge T itself: done=1, result, carry, ovf and err update, state stays IDLE. Latency is 1 cycle.
- mul at edge T: state goes to MUL, busy=1, accumulator=0, multiplicand=a zero-extended to 2*WIDTH bits, multiplier=b, counter=0.
- Each MUL edge:
  - if multiplier LSB is 1, accumulator += multiplicand;
  - multiplicand shifts left 1; multiplier shifts right 1; counter increments.
- On the WIDTH-th MUL edge (edge T+WIDTH):
  - result = final accumulator, carry=0, err=0, ovf = |result[2W-1:W];
  - busy=0, done=1, state returns to IDLE.
  - Multiply latency is exactly WIDTH+1 edges from accept.
- Early termination when the multiplier becomes 0 is not allowed; latency is fixed.
- done is high for exactly one cycle. A start sampled during the done cycle is accepted; this gives back-to-back operations with no idle gap.
- result and flags hold their values until the next completion, not merely until the next accept. Mid-multiply, result still shows the previous value.
- Arithmetic rules:
  - add: result[W-1:0] = (a+b) mod 2^W; result[2W-1:W] = 0; carry = bit W of a+b; ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - sub: result[W-1:0] = (a-b) mod 2^W; upper bits 0; carry=1 iff a<b unsigned; ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
  - invalid: result=0, err=1, carry=0, ovf=0.
- Reset asserted mid-operation aborts immediately and asynchronously to reset values. No done is produced for the aborted op. The first start after rst deasserts is accepted normally.
- Operand changes while busy have no effect on the result.

Test Plan:
1. WIDTH=4. add a=1111, b=1111 -> next edge done=1, result=0x0E, carry=1, ovf=0. Then a=1001, b=0110 -> result=0x0F, carry=0, ovf=0.
2. add a=0101, b=1100 -> result=0x01, carry=1, ovf=0. add a=0111, b=0001 -> result=0x08, carry=0, ovf=1.
3. sub a=0001, b=1111 -> result=0x02, carry=1, ovf=0. sub a=1000, b=0001 -> result=0x07, carry=0, ovf=1.
4. mul a=1111, b=1111 accepted at edge T:
   - busy=1 at edges T..T+3;
   - done=1 only after edge T+4, with result=0xE1, ovf=1, carry=0.
   - mul a=0011, b=0010 -> result=0x06, ovf=0.
5. Handshake:
   - start held high throughout a multiply -> no re-accept while busy; the new op is accepted in the done cycle, giving back-to-back completions.
   - op=11 -> err=1, result=0, done pulses once.
6. Reset mid-operation:
   - rst asserted between edges mid-multiply -> outputs go 0 immediately without waiting for a clock edge, and no done appears.
   - After release, add 0001+0001 -> result=0x02 one edge after accept.
   - Repeat cases 1–4 with WIDTH=8, e.g. mul 0xFF*0xFF -> result=0xFE01 after 9 edges.
